// File: rtl/mm_bus_arbiter_if.sv
// Bus bundle between two requesters (R0 = CPU, R1 = DMA/debug), the arbiter and one peripheral port.
// slave  : arbiter view (samples requests and per_rdy/per_rdata, drives acks, rdata, err and per_* strobes).
// master : environment view (drives requests and the peripheral response, observes the rest).
interface mm_bus_arbiter_if;
  // Requester 0
  logic        req0;
  logic        we0;
  logic [15:0] addr0;
  logic [15:0] wdata0;
  logic        ack0;
  logic [15:0] rdata0;
  // Requester 1
  logic        req1;
  logic        we1;
  logic [15:0] addr1;
  logic [15:0] wdata1;
  logic        ack1;
  logic [15:0] rdata1;
  // Completion status shared by both requesters
  logic        err;
  // Peripheral port
  logic        per_re;
  logic        per_we;
  logic [15:0] per_addr;
  logic [15:0] per_wdata;
  logic [15:0] per_rdata;
  logic        per_rdy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1, err,
    output per_re, per_we, per_addr, per_wdata,
    input  per_rdata, per_rdy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1, err,
    input  per_re, per_we, per_addr, per_wdata,
    output per_rdata, per_rdy
  );
endinterface

// File: rtl/mm_bus_arbiter.sv
// Purpose: two-requester arbiter for the external memory-mapped bus, driving one peripheral port.
// Latency: request sampled in IDLE cycle t -> strobe in t+1 -> ack in t+2 at best; per_rdy stretches ACCESS.
// Backpressure: per_rdy low holds the strobe; after TIMEOUT strobe cycles the access aborts with err.
// Ports: clk, rst (sync, active high); bus (slave modport): req/we/addr/wdata in and ack/rdata out per
//        requester, shared err pulse, per_re/per_we/per_addr/per_wdata out, per_rdata/per_rdy in.
module mm_bus_arbiter #(
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input logic             clk,
  input logic             rst,
  mm_bus_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;           // id of the requester being served
  logic          last_gnt_q, last_gnt_d; // id served most recently, loses the next tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          per_re_q, per_re_d;
  logic          per_we_q, per_we_d;
  logic [15:0]   per_addr_q, per_addr_d;
  logic [15:0]   per_wdata_q, per_wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [15:0]   rdata0_q, rdata0_d;
  logic [15:0]   rdata1_q, rdata1_d;

  logic          sel;      // requester chosen in IDLE
  logic          sel_we;
  logic          fin;      // ACCESS ends this cycle
  logic [15:0]   fin_data; // data returned to the requester on a read

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    per_re_d    = 1'b0;
    per_we_d    = 1'b0;
    per_addr_d  = per_addr_q;
    per_wdata_d = per_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    sel         = 1'b0;
    sel_we      = 1'b0;
    fin         = 1'b0;
    fin_data    = bus.per_rdata;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins; otherwise the lone requester.
          sel         = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
          sel_we      = sel ? bus.we1 : bus.we0;
          gnt_d       = sel;
          last_gnt_d  = sel;
          cnt_d       = '0;
          per_re_d    = ~sel_we;
          per_we_d    = sel_we;
          per_addr_d  = sel ? bus.addr1 : bus.addr0;
          per_wdata_d = sel ? bus.wdata1 : bus.wdata0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        per_re_d = per_re_q;
        per_we_d = per_we_q;
        // per_rdy is checked first so it wins over a coinciding timeout.
        if (bus.per_rdy) begin
          fin = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin      = 1'b1;
          fin_data = ERR_DATA;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (fin) begin
          state_d  = DONE;
          per_re_d = 1'b0;
          per_we_d = 1'b0;
          ack0_d   = ~gnt_q;
          ack1_d   = gnt_q;
          // per_we_q still holds the access direction here; writes keep rdata.
          if (!per_we_q) begin
            if (gnt_q) rdata1_d = fin_data;
            else       rdata0_d = fin_data;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      per_re_q    <= 1'b0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      per_re_q    <= per_re_d;
      per_we_q    <= per_we_d;
      per_addr_q  <= per_addr_d;
      per_wdata_q <= per_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.err       = err_q;
  assign bus.per_re    = per_re_q;
  assign bus.per_we    = per_we_q;
  assign bus.per_addr  = per_addr_q;
  assign bus.per_wdata = per_wdata_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: reset, single read, tie-break alternation, wait-stated write,
// timeout abort, reset during an access and per_rdy on the last allowed cycle.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mm_bus_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mm_bus_arbiter_if bus ();

  mm_bus_arbiter #(
    .TIMEOUT (15),
    .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.per_rdy = 1'b0; bus.per_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raises one request and plays the peripheral: per_rdy goes high in strobe cycle rdy_at (0 = never).
  // lat counts falling edges from raising req to seeing ack (2 = minimum).
  task automatic run_access(input logic id, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input int rdy_at, input logic [15:0] prd,
                            output int strobe_n, output int re_n, output int lat,
                            output logic errv, output logic wrong_ack,
                            output logic [15:0] seen_addr, output logic [15:0] seen_wdata);
    strobe_n = 0; re_n = 0; lat = -1; errv = 1'b0; wrong_ack = 1'b0;
    seen_addr = '0; seen_wdata = '0;
    @(negedge clk);
    if (id) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.per_rdy = 1'b0;
      if (bus.per_re || bus.per_we) begin
        strobe_n++;
        if (bus.per_re) re_n++;
        seen_addr  = bus.per_addr;
        seen_wdata = bus.per_wdata;
        if (strobe_n == rdy_at) begin
          bus.per_rdy   = 1'b1;
          bus.per_rdata = prd;
        end
      end
      if (id ? bus.ack0 : bus.ack1) wrong_ack = 1'b1;
      if (id ? bus.ack1 : bus.ack0) begin
        lat  = c;
        errv = bus.err;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.per_rdy = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.err, bus.per_re, bus.per_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.ack0, bus.ack1, bus.err, bus.per_re, bus.per_we});
    end
    n_cmp++;
    if ({bus.per_addr, bus.per_wdata, bus.rdata0, bus.rdata1} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0",
               {bus.per_addr, bus.per_wdata, bus.rdata0, bus.rdata1});
    end
  endtask

  task automatic test_single_read();
    int sn, rn, lat;
    logic ev, wa;
    logic [15:0] sa, sw;
    run_access(1'b0, 1'b0, 16'hC001, 16'h0000, 1, 16'h00A5, sn, rn, lat, ev, wa, sa, sw);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL rd_latency: got %0d want 2", lat); end
    n_cmp++;
    if (sn !== 1 || rn !== 1) begin
      n_err++; $display("FAIL rd_strobe: got strobes=%0d re=%0d want 1/1", sn, rn);
    end
    n_cmp++;
    if (sa !== 16'hC001) begin n_err++; $display("FAIL rd_addr: got %h want c001", sa); end
    n_cmp++;
    if (bus.rdata0 !== 16'h00A5 || ev !== 1'b0 || wa !== 1'b0) begin
      n_err++;
      $display("FAIL rd_result: got rdata0=%h err=%b ack1=%b want 00a5/0/0", bus.rdata0, ev, wa);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ack0 !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse: got ack0=%b want 0", bus.ack0); end
  endtask

  task automatic test_alternation();
    int order[4];
    int ng;
    logic rearm0, rearm1;
    apply_reset();
    ng = 0; rearm0 = 1'b0; rearm1 = 1'b0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h2100;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h2200;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      bus.per_rdy = 1'b0;
      if (rearm0) begin bus.req0 = 1'b1; rearm0 = 1'b0; end
      if (rearm1) begin bus.req1 = 1'b1; rearm1 = 1'b0; end
      if (bus.per_re) begin
        bus.per_rdy   = 1'b1;
        bus.per_rdata = bus.per_addr ^ 16'hFFFF;
      end
      n_cmp++;
      if (bus.ack0 && bus.ack1) begin n_err++; $display("FAIL alt_dual_ack: got both acks high want one"); end
      if (bus.ack0) begin
        order[ng] = 0; ng++;
        n_cmp++;
        if (bus.rdata0 !== 16'hDEFF) begin n_err++; $display("FAIL alt_rdata0: got %h want deff", bus.rdata0); end
        bus.req0 = 1'b0; rearm0 = 1'b1;
      end else if (bus.ack1) begin
        order[ng] = 1; ng++;
        n_cmp++;
        if (bus.rdata1 !== 16'hDDFF) begin n_err++; $display("FAIL alt_rdata1: got %h want ddff", bus.rdata1); end
        bus.req1 = 1'b0; rearm1 = 1'b1;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.per_rdy = 1'b0;
    n_cmp++;
    if (ng !== 4) begin n_err++; $display("FAIL alt_count: got %0d grants want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++;
      if (order[i] !== (i % 2)) begin
        n_err++; $display("FAIL alt_order[%0d]: got R%0d want R%0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_wait_write();
    int sn, rn, lat;
    logic ev, wa;
    logic [15:0] sa, sw;
    run_access(1'b1, 1'b1, 16'hC000, 16'h0155, 4, 16'h7777, sn, rn, lat, ev, wa, sa, sw);
    n_cmp++;
    if (sn !== 4 || rn !== 0) begin
      n_err++; $display("FAIL wr_strobe: got strobes=%0d re=%0d want 4/0", sn, rn);
    end
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL wr_latency: got %0d want 5", lat); end
    n_cmp++;
    if (sa !== 16'hC000 || sw !== 16'h0155) begin
      n_err++; $display("FAIL wr_bus: got addr=%h wdata=%h want c000/0155", sa, sw);
    end
    n_cmp++;
    if (bus.rdata1 !== 16'hDDFF || ev !== 1'b0 || wa !== 1'b0) begin
      n_err++;
      $display("FAIL wr_result: got rdata1=%h err=%b ack0=%b want ddff/0/0", bus.rdata1, ev, wa);
    end
  endtask

  task automatic test_timeout();
    int sn, rn, lat;
    logic ev, wa;
    logic [15:0] sa, sw;
    run_access(1'b0, 1'b0, 16'h2400, 16'h0000, 0, 16'h1111, sn, rn, lat, ev, wa, sa, sw);
    n_cmp++;
    if (sn !== 15 || rn !== 15) begin
      n_err++; $display("FAIL to_strobe: got strobes=%0d re=%0d want 15/15", sn, rn);
    end
    n_cmp++;
    if (lat !== 16 || ev !== 1'b1) begin
      n_err++; $display("FAIL to_ack: got latency=%0d err=%b want 16/1", lat, ev);
    end
    n_cmp++;
    if (bus.rdata0 !== 16'hDEAD) begin n_err++; $display("FAIL to_rdata: got %h want dead", bus.rdata0); end
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got err=%b want 0", bus.err); end
  endtask

  task automatic test_reset_mid_access();
    int sn, rn, lat;
    logic ev, wa;
    logic [15:0] sa, sw;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h2300;
    @(negedge clk);
    n_cmp++;
    if (bus.per_re !== 1'b1) begin n_err++; $display("FAIL rst_mid_start: got per_re=%b want 1", bus.per_re); end
    rst = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.err, bus.per_re, bus.per_we, bus.per_addr, bus.rdata0, bus.rdata1} !== 53'h0) begin
      n_err++;
      $display("FAIL rst_mid_clear: got ack0=%b ack1=%b err=%b re=%b we=%b addr=%h rdata0=%h rdata1=%h want all 0",
               bus.ack0, bus.ack1, bus.err, bus.per_re, bus.per_we, bus.per_addr, bus.rdata0, bus.rdata1);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ack0 !== 1'b0 || bus.per_re !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_noack: got ack0=%b per_re=%b want 0/0", bus.ack0, bus.per_re);
    end
    run_access(1'b0, 1'b0, 16'h2500, 16'h0000, 1, 16'h0BEE, sn, rn, lat, ev, wa, sa, sw);
    n_cmp++;
    if (lat !== 2 || bus.rdata0 !== 16'h0BEE || ev !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_fresh: got latency=%0d rdata0=%h err=%b want 2/0bee/0", lat, bus.rdata0, ev);
    end
  endtask

  task automatic test_rdy_at_limit();
    int sn, rn, lat;
    logic ev, wa;
    logic [15:0] sa, sw;
    run_access(1'b0, 1'b0, 16'h2600, 16'h0000, 15, 16'h1234, sn, rn, lat, ev, wa, sa, sw);
    n_cmp++;
    if (sn !== 15 || lat !== 16) begin
      n_err++; $display("FAIL lim_timing: got strobes=%0d latency=%0d want 15/16", sn, lat);
    end
    n_cmp++;
    if (ev !== 1'b0 || bus.rdata0 !== 16'h1234) begin
      n_err++; $display("FAIL lim_result: got err=%b rdata0=%h want 0/1234", ev, bus.rdata0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_alternation();
    test_wait_write();
    test_timeout();
    test_reset_mid_access();
    test_rdy_at_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
